// File: rtl/rand_dispatcher.sv
// Round-robin dispatcher that hands a registered snapshot of the shared LFSR
// value to one requester at a time, with a fixed cooldown between grants.
module rand_dispatcher #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 10,
  parameter int GAP   = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [WIDTH-1:0]        rand_in,
  input  logic [NREQ-1:0]         req,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] gnt_id,
  output logic [WIDTH-1:0]        rand_out,
  output logic                    rand_valid,
  output logic                    busy
);

  localparam int IDW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || GAP < 1 || GAP > 255) begin : g_param_err
    $error("rand_dispatcher: NREQ must be 2..8 and GAP must be 1..255");
  end

  typedef enum logic {READY, COOLDOWN} state_t;

  state_t           state, state_nxt;
  logic [7:0]       gap_cnt, gap_nxt;
  logic [IDW-1:0]   ptr, ptr_nxt;
  logic [IDW-1:0]   win, idx;
  logic [IDW:0]     sum;
  logic             found, take;

  logic [NREQ-1:0]  gnt_nxt;
  logic [IDW-1:0]   id_nxt;
  logic [WIDTH-1:0] rand_nxt;
  logic             valid_nxt, busy_nxt;

  // Scan requesters starting at ptr and wrapping; first set bit wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
      idx = sum[IDW-1:0];
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign take = (state == READY) && en && found;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= READY;
      gap_cnt    <= '0;
      ptr        <= '0;
      gnt        <= '0;
      gnt_id     <= '0;
      rand_out   <= '0;
      rand_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      gap_cnt    <= gap_nxt;
      ptr        <= ptr_nxt;
      gnt        <= gnt_nxt;
      gnt_id     <= id_nxt;
      rand_out   <= rand_nxt;
      rand_valid <= valid_nxt;
      busy       <= busy_nxt;
    end
  end

  // The cooldown counts down regardless of en so a paused grant source never stretches the gap.
  always_comb begin
    state_nxt = state;
    gap_nxt   = gap_cnt;
    ptr_nxt   = ptr;
    case (state)
      READY: begin
        if (take) begin
          ptr_nxt = (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;
          if (GAP > 1) begin
            state_nxt = COOLDOWN;
            gap_nxt   = 8'(GAP-1);
          end
        end
      end
      COOLDOWN: begin
        gap_nxt = gap_cnt - 8'd1;
        if (gap_cnt <= 8'd1) begin
          state_nxt = READY;
          gap_nxt   = '0;
        end
      end
      default: state_nxt = READY;
    endcase
  end

  always_comb begin
    gnt_nxt   = '0;
    id_nxt    = gnt_id;
    rand_nxt  = rand_out;
    valid_nxt = 1'b0;
    busy_nxt  = (state_nxt == COOLDOWN);
    if (take) begin
      gnt_nxt   = NREQ'(1) << win;
      id_nxt    = win;
      rand_nxt  = rand_in;
      valid_nxt = 1'b1;
    end
  end

endmodule

// File: tb/tb_rand_dispatcher.sv
// Bench for rand_dispatcher: a 4-requester/GAP=10 instance and a 2-requester/GAP=1
// instance, both compared every cycle against a cycle-count based reference model.
module tb_rand_dispatcher;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [9:0] rand_in;
  logic [3:0] req;
  logic [1:0] req2;

  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic [9:0] rand_out;
  logic       rand_valid, busy;

  logic [1:0] gnt2;
  logic       gnt_id2;
  logic [9:0] rand_out2;
  logic       rand_valid2, busy2;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int         nreq[2] = '{4, 2};
  int         gap[2]  = '{10, 1};
  int         m_ready_at[2];
  int         m_ptr[2];
  int         m_id[2];
  logic [9:0] m_rand[2];
  logic [3:0] m_gnt[2];
  logic       m_busy[2];

  rand_dispatcher #(.NREQ(4), .WIDTH(10), .GAP(10)) dut (
    .clk(clk), .rst(rst), .en(en), .rand_in(rand_in), .req(req),
    .gnt(gnt), .gnt_id(gnt_id), .rand_out(rand_out),
    .rand_valid(rand_valid), .busy(busy)
  );

  rand_dispatcher #(.NREQ(2), .WIDTH(10), .GAP(1)) dut2 (
    .clk(clk), .rst(rst), .en(en), .rand_in(rand_in), .req(req2),
    .gnt(gnt2), .gnt_id(gnt_id2), .rand_out(rand_out2),
    .rand_valid(rand_valid2), .busy(busy2)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int pickWinner(input logic [3:0] r, input int p, input int n);
    for (int k = 0; k < n; k++) begin
      if (r[(p + k) % n]) return (p + k) % n;
    end
    return -1;
  endfunction

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      m_ready_at[d] = 0;
      m_ptr[d]      = 0;
      m_id[d]       = 0;
      m_rand[d]     = '0;
      m_gnt[d]      = '0;
      m_busy[d]     = 1'b0;
    end
  endtask

  // A grant is allowed once GAP edges have elapsed since the previous grant.
  task automatic modelEdge();
    logic [3:0] r;
    int         w;
    cyc++;
    if (rst) begin
      modelReset();
      return;
    end
    for (int d = 0; d < 2; d++) begin
      r = (d == 0) ? req : {2'b00, req2};
      w = -1;
      if (en && cyc >= m_ready_at[d]) w = pickWinner(r, m_ptr[d], nreq[d]);
      if (w >= 0) begin
        m_gnt[d]      = 4'(1 << w);
        m_id[d]       = w;
        m_rand[d]     = rand_in;
        m_ptr[d]      = (w + 1) % nreq[d];
        m_ready_at[d] = cyc + gap[d];
      end else begin
        m_gnt[d] = '0;
      end
      m_busy[d] = (cyc + 1 < m_ready_at[d]);
    end
  endtask

  task automatic checkOutput();
    checkVal("gnt",         32'(gnt),         32'(m_gnt[0]));
    checkVal("gnt_id",      32'(gnt_id),      32'(m_id[0]));
    checkVal("rand_out",    32'(rand_out),    32'(m_rand[0]));
    checkVal("rand_valid",  32'(rand_valid),  32'(m_gnt[0] != 0));
    checkVal("busy",        32'(busy),        32'(m_busy[0]));
    checkVal("gnt2",        32'(gnt2),        32'(m_gnt[1]));
    checkVal("gnt_id2",     32'(gnt_id2),     32'(m_id[1]));
    checkVal("rand_out2",   32'(rand_out2),   32'(m_rand[1]));
    checkVal("rand_valid2", 32'(rand_valid2), 32'(m_gnt[1] != 0));
    checkVal("busy2",       32'(busy2),       32'(m_busy[1]));
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput();
  endtask

  task automatic waitReady();
    for (int i = 0; i < 20 && (cyc + 1 < m_ready_at[0]); i++) applyStimulus();
  endtask

  initial begin
    rst     = 1'b1;
    en      = 1'b1;
    req     = 4'b1111;
    req2    = 2'b11;
    rand_in = '0;
    modelReset();
    #1;
    checkOutput();
    repeat (2) applyStimulus();

    $display("[TB] reset release and first grant");
    rst     = 1'b0;
    rand_in = 10'h2AB;
    applyStimulus();
    checkVal("first_gnt",  32'(gnt),      32'h1);
    checkVal("first_rand", 32'(rand_out), 32'h2AB);

    $display("[TB] round-robin with continuous requests");
    repeat (44) begin
      rand_in = 10'($urandom);
      applyStimulus();
    end

    $display("[TB] requests during cooldown are ignored");
    req = 4'b0000;
    waitReady();
    req = 4'b0001;
    applyStimulus();
    req = 4'b0000;
    applyStimulus();
    req = 4'b0100;
    repeat (4) applyStimulus();
    req = 4'b0000;
    checkVal("cool_id", 32'(gnt_id), 32'h0);
    waitReady();

    $display("[TB] pointer skip and single requester");
    req = 4'b1001;
    repeat (25) begin
      rand_in = 10'($urandom);
      applyStimulus();
    end
    req = 4'b0001;
    repeat (30) begin
      rand_in = 10'($urandom);
      applyStimulus();
    end

    $display("[TB] enable gating");
    req = 4'b0000;
    waitReady();
    en  = 1'b0;
    req = 4'b0100;
    repeat (5) applyStimulus();
    en = 1'b1;
    applyStimulus();
    checkVal("en_gnt", 32'(gnt), 32'h4);

    $display("[TB] asynchronous reset mid-cooldown");
    req = 4'b0000;
    repeat (3) applyStimulus();
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput();
    applyStimulus();
    rst = 1'b0;
    req = 4'b0110;
    applyStimulus();
    checkVal("post_rst_gnt", 32'(gnt), 32'h2);

    $display("[TB] randomized traffic");
    repeat (400) begin
      req     = 4'($urandom);
      req2    = 2'($urandom);
      en      = ($urandom % 8) != 0;
      rand_in = 10'($urandom);
      applyStimulus();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
